tinyml_source_common_reset_seq: RTL
===================================

Name: tinyml_source_common_reset_seq

Overview:
- Reset initiator for the vision pipeline. It collects reset causes (power-on, software request, watchdog expiry, PLL lock loss) and drives active-high asynchronous reset requests to NUM_DOMAIN clock domains.
- Each domain output feeds that domain's reset synchronizer.
- All domains are asserted together. Release is held off until the PLL is stably locked, then domains are released in a staggered order: domain 0 first, e.g. memory/DMA before the camera/display front ends.

Parameters:
- NUM_DOMAIN, 3: number of domain reset outputs; minimum 1.
- HOLD_CYCLE, 16: cycles all outputs stay asserted after any reset cause; minimum 1.
- STAGGER_CYCLE, 8: cycles between consecutive domain releases; minimum 1.
- LOCK_FILTER, 4: consecutive synchronized lock-high cycles needed before lock is deemed stable; minimum 1.

Ports:
- i_clk, input, 1: free-running reference clock (not PLL-derived).
- i_arstn, input, 1: asynchronous active-low reset, power-on cause.
- i_pll_locked, input, 1: PLL lock, asynchronous to i_clk.
- i_sw_rst_req, input, 1: software reset request, single-cycle pulse, i_clk domain.
- i_wdt_expire, input, 1: watchdog expiry, single-cycle pulse, i_clk domain.
- o_arst, output, NUM_DOMAIN: per-domain reset request, active-high.
- o_busy, output, 1: high while any o_arst bit is asserted.
- o_rst_done, output, 1: one-cycle pulse when the last domain is released.
- o_rst_cause, output, 2: last reset cause. 00 = POR, 01 = software, 10 = watchdog, 11 = lock loss.

Behaviour:
- Clock and reset: i_clk is the only clock. i_arstn is asynchronous and active-low.
- While i_arstn is low: o_arst = all ones, o_busy = 1, o_rst_done = 0, o_rst_cause = 00, FSM = ASSERT, all counters = 0, lock synchronizer flops = 0.
- All outputs are registered. No combinational path from any input to any output.
- Lock synchronizer: i_pll_locked passes through a 2-flop synchronizer, giving lock_s.
- Lock filter: counts consecutive lock_s = 1 cycles, saturating at LOCK_FILTER. Any lock_s = 0 clears it to 0 on that cycle. It runs in every state. lock_ok = (filter == LOCK_FILTER).
- Cycle numbering: cycle 0 is the first rising edge with i_arstn high. The state and o_arst update on the same edge.
- FSM states: ASSERT, WAIT_LOCK, RELEASE, RUN.
- ASSERT:
  - o_arst = all ones; hold counter increments each cycle.
  - After HOLD_CYCLE cycles in ASSERT: go to RELEASE if lock_ok, otherwise WAIT_LOCK.
  - Any new cause while in ASSERT reloads the hold counter to 0 and updates o_rst_cause.
- WAIT_LOCK:
  - o_arst = all ones. Go to RELEASE on the first cycle lock_ok = 1.
  - sw/wdt pulses return the FSM to ASSERT.
- RELEASE:
  - On the entry edge, o_arst[0] is cleared.
  - Every STAGGER_CYCLE cycles afterwards, the next index is cleared, in ascending order.
  - Once a domain is cleared it stays cleared until the next reset cause.
  - On the edge that clears o_arst[NUM_DOMAIN-1]: go to RUN, o_busy = 0, o_rst_done = 1 for exactly one cycle.
  - If NUM_DOMAIN = 1, that is the RELEASE entry edge.
- RUN: o_arst = all zeros; wait for a cause.
- Cause handling in RELEASE or RUN:
  - Cause events: i_sw_rst_req = 1, i_wdt_expire = 1, or lock-loss (lock_s falling, 1 -> 0).
  - On the next edge: o_arst = all ones, o_busy = 1, FSM = ASSERT, hold and stagger counters = 0.
  - Partial release is abandoned.
- Lock-loss in ASSERT or WAIT_LOCK only clears the filter. It does not change o_rst_cause.
- Simultaneous causes: priority lock-loss > watchdog > software. o_rst_cause records the highest-priority cause.
- o_rst_cause is sticky until the next cause or i_arstn.
- Software/watchdog pulses are not queued. A pulse that arrives while in ASSERT only extends the hold (counter reload).
- Mid-operation i_arstn assertion: all outputs immediately return to their reset values, asynchronously.

Test Plan:
1. POR, default params, i_pll_locked = 1 throughout, i_arstn released before cycle 0 -> o_arst = 111 for cycles 0-15; o_arst[0] = 0 from edge 16, [1] from edge 24, [2] from edge 32; o_rst_done high only in the cycle after edge 32; o_rst_cause = 00.
2. POR with i_pll_locked = 0 until cycle 40, then 1 -> FSM in WAIT_LOCK; o_arst = 111 until lock_ok (sync 2 + filter 4 cycles after cycle 40); staggered 8-cycle release follows.
3. In RUN, assert i_sw_rst_req and i_wdt_expire in the same cycle -> o_arst = 111 next edge; o_rst_cause = 10; full 16-cycle hold then staggered release.
4. Drop i_pll_locked while o_arst = 110 (RELEASE) -> all ones 3 edges later (2 sync + 1); o_rst_cause = 11; held in WAIT_LOCK until lock is stable again.
5. Repeated i_sw_rst_req every 10 cycles in ASSERT -> hold counter reloads each time; no release until 16 quiet cycles.
6. Assert i_arstn low mid-RELEASE -> o_arst = 111, o_busy = 1, o_rst_cause = 00 without a clock edge; sequence restarts from cycle 0 on release.

Source files
------------

// File: rtl/tinyml_source_common_reset_seq.sv
// ---------------------------------------------------------------------------
// tinyml_source_common_reset_seq
//
// Reset initiator for the vision pipeline. Collects reset causes (power-on,
// software request, watchdog expiry, PLL lock loss) and drives active-high
// asynchronous reset requests to NUM_DOMAIN clock domains. All domains are
// asserted together; release waits for a stable PLL lock and then frees the
// domains one by one, domain 0 first, STAGGER_CYCLE cycles apart.
//
// Ports:
//   i_clk         free-running reference clock (not PLL-derived)
//   i_arstn       asynchronous active-low reset, power-on cause
//   i_pll_locked  PLL lock, asynchronous to i_clk
//   i_sw_rst_req  software reset request, single-cycle pulse
//   i_wdt_expire  watchdog expiry, single-cycle pulse
//   o_arst        per-domain reset request, active-high
//   o_busy        high while any o_arst bit is asserted
//   o_rst_done    one-cycle pulse when the last domain is released
//   o_rst_cause   last cause: 00 POR, 01 software, 10 watchdog, 11 lock loss
//   o_dbg_state   current FSM state (ASSERT/WAIT_LOCK/RELEASE/RUN)
//
// Handshake note: there is no valid/ready traffic here; the cause inputs
// are level-sampled single-cycle pulses and every output is a register.
// ---------------------------------------------------------------------------
module tinyml_source_common_reset_seq #(
    parameter int NUM_DOMAIN    = 3,
    parameter int HOLD_CYCLE    = 16,
    parameter int STAGGER_CYCLE = 8,
    parameter int LOCK_FILTER   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic                  i_pll_locked,
    input  logic                  i_sw_rst_req,
    input  logic                  i_wdt_expire,
    output logic [NUM_DOMAIN-1:0] o_arst,
    output logic                  o_busy,
    output logic                  o_rst_done,
    output logic [1:0]            o_rst_cause,
    output logic [1:0]            o_dbg_state
);

    localparam int HOLD_W = $clog2(HOLD_CYCLE + 1);
    localparam int FLT_W  = $clog2(LOCK_FILTER + 1);
    localparam int STG_W  = (STAGGER_CYCLE > 1) ? $clog2(STAGGER_CYCLE) : 1;
    localparam int IDX_W  = (NUM_DOMAIN > 1) ? $clog2(NUM_DOMAIN) : 1;

    localparam logic [HOLD_W-1:0]     HOLD_MAX = HOLD_W'(HOLD_CYCLE);
    localparam logic [FLT_W-1:0]      FLT_MAX  = FLT_W'(LOCK_FILTER);
    localparam logic [STG_W-1:0]      STG_MAX  = STG_W'(STAGGER_CYCLE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DOMAIN - 1);
    localparam logic [NUM_DOMAIN-1:0] ONE      = NUM_DOMAIN'(1);
    localparam logic [NUM_DOMAIN-1:0] ALL      = {NUM_DOMAIN{1'b1}};

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;
    localparam logic [1:0] CAUSE_LOCK = 2'b11;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STG_W-1:0]  stg_cnt;
    logic [IDX_W-1:0]  rel_idx;   // next domain to release

    // Lock synchronizer, previous-value flop for edge detection, filter.
    logic             lock_m;
    logic             lock_s;
    logic             lock_d;
    logic [FLT_W-1:0] lock_flt;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            lock_m   <= 1'b0;
            lock_s   <= 1'b0;
            lock_d   <= 1'b0;
            lock_flt <= '0;
        end else begin
            lock_m <= i_pll_locked;
            lock_s <= lock_m;
            lock_d <= lock_s;
            if (!lock_s)
                lock_flt <= '0;
            else if (lock_flt != FLT_MAX)
                lock_flt <= lock_flt + FLT_W'(1);
        end
    end

    logic       lock_ok;
    logic       lock_fall;
    logic       pulse_any;
    logic       run_any;
    logic [1:0] pulse_cause;
    logic [1:0] run_cause;

    // Lock loss only counts as a cause once the sequence has left the
    // assert/wait phase; before that it merely restarts the filter.
    assign lock_ok     = (lock_flt == FLT_MAX);
    assign lock_fall   = lock_d & ~lock_s;
    assign pulse_any   = i_sw_rst_req | i_wdt_expire;
    assign run_any     = pulse_any | lock_fall;
    assign pulse_cause = i_wdt_expire ? CAUSE_WDT : CAUSE_SW;
    assign run_cause   = lock_fall ? CAUSE_LOCK : pulse_cause;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state       <= ST_ASSERT;
            hold_cnt    <= '0;
            stg_cnt     <= '0;
            rel_idx     <= '0;
            o_arst      <= ALL;
            o_busy      <= 1'b1;
            o_rst_done  <= 1'b0;
            o_rst_cause <= CAUSE_POR;
        end else begin
            o_rst_done <= 1'b0;
            case (state)
                ST_ASSERT: begin
                    if (pulse_any) begin
                        // A new pulse restarts the full hold time.
                        hold_cnt    <= '0;
                        o_rst_cause <= pulse_cause;
                    end else if (hold_cnt == HOLD_MAX) begin
                        if (lock_ok) begin
                            stg_cnt <= '0;
                            rel_idx <= IDX_W'(1);
                            o_arst  <= ~ONE;
                            if (NUM_DOMAIN == 1) begin
                                state      <= ST_RUN;
                                o_busy     <= 1'b0;
                                o_rst_done <= 1'b1;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end else begin
                            state <= ST_WAIT_LOCK;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    if (pulse_any) begin
                        state       <= ST_ASSERT;
                        hold_cnt    <= '0;
                        o_rst_cause <= pulse_cause;
                    end else if (lock_ok) begin
                        stg_cnt <= '0;
                        rel_idx <= IDX_W'(1);
                        o_arst  <= ~ONE;
                        if (NUM_DOMAIN == 1) begin
                            state      <= ST_RUN;
                            o_busy     <= 1'b0;
                            o_rst_done <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (run_any) begin
                        // Abandon the partial release and start over.
                        state       <= ST_ASSERT;
                        hold_cnt    <= '0;
                        stg_cnt     <= '0;
                        o_arst      <= ALL;
                        o_busy      <= 1'b1;
                        o_rst_cause <= run_cause;
                    end else if (stg_cnt == STG_MAX) begin
                        stg_cnt <= '0;
                        o_arst  <= o_arst & ~(ONE << rel_idx);
                        rel_idx <= rel_idx + IDX_W'(1);
                        if (rel_idx == IDX_LAST) begin
                            state      <= ST_RUN;
                            o_busy     <= 1'b0;
                            o_rst_done <= 1'b1;
                        end
                    end else begin
                        stg_cnt <= stg_cnt + STG_W'(1);
                    end
                end

                ST_RUN: begin
                    if (run_any) begin
                        state       <= ST_ASSERT;
                        hold_cnt    <= '0;
                        stg_cnt     <= '0;
                        o_arst      <= ALL;
                        o_busy      <= 1'b1;
                        o_rst_cause <= run_cause;
                    end
                end

                default: begin
                    state  <= ST_ASSERT;
                    o_arst <= ALL;
                    o_busy <= 1'b1;
                end
            endcase
        end
    end

    assign o_dbg_state = state;

endmodule
